serial_wide_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock, least-significant nibble first.
- Each cycle, the current nibble is fed to the existing `adder_4bit`, and its `sum` and `cout` are consumed back into shift and carry registers.
- It is the sequencing stage directly around the nibble adder and turns that 4-bit combinational datapath into a wide, flow-controlled arithmetic unit.
- Valid/ready handshakes are used on both input and output.

---
 rtl/wadd_pkg.sv | 14 +
 rtl/adder_4bit.sv | 17 +
 rtl/serial_wide_adder.sv | 150 +++++++++++++++
 tb/tb_serial_wide_adder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wadd_pkg.sv
// Shared types and constants for the serial wide adder.
//   wadd_state_t : sequencing states (IDLE, RUN, DONE)
//   NIB_BITS     : bits consumed per clock by the nibble datapath
package wadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wadd_state_t;

    localparam int NIB_BITS = 4;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit combinational ripple adder used as the per-cycle datapath.
// Ports:
//   a, b : 4-bit operands
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_wide_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LS nibble first, with
// valid/ready handshakes on input and output.
// Optional feature macro: WADD_SUB_EN (adds op_sub port, A - B mode).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin    : operands and LS carry-in
//   op_sub                : subtract select (only with WADD_SUB_EN)
//   out_valid / out_ready : result handshake
//   out_sum, out_cout     : result and MSB carry-out
//   out_ovf               : two's-complement overflow
//   busy                  : operation in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per cycle, NIB cycles
// DONE  | result held until out_ready
module serial_wide_adder
    import wadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef WADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : g_bad_width
            $error("serial_wide_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    wadd_state_t      r_state;
    wadd_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_msb_a;
    logic             r_msb_b;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;

`ifdef WADD_SUB_EN
    assign w_sub = op_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is A + ~B + 1; in_cin is ignored in that mode.
    assign w_b_eff   = w_sub ? ~in_b : in_b;
    assign w_cin_eff = w_sub ? 1'b1 : in_cin;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    adder_4bit u_nib (
        .a    (r_a[3:0]),
        .b    (r_b[3:0]),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_msb_a <= 1'b0;
            r_msb_b <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_msb_a <= in_a[WIDTH-1];
            r_msb_b <= w_b_eff[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            // Nibble sums enter from the top; after NIB shifts the
            // first one sits at bit 0.
            r_sum   <= WIDTH'({w_nib_sum, r_sum} >> NIB_BITS);
            r_a     <= r_a >> NIB_BITS;
            r_b     <= r_b >> NIB_BITS;
            r_carry <= w_nib_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_nib_cout;
                r_ovf  <= (r_msb_a == r_msb_b) && (w_nib_sum[3] != r_msb_a);
            end
        end
    end

endmodule

// File: tb/tb_serial_wide_adder.sv
module tb_serial_wide_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;
`ifdef WADD_SUB_EN
    logic          op_sub;
    logic          v4_op_sub;
`endif

    logic          v4_in_valid;
    logic          v4_in_ready;
    logic [3:0]    v4_in_a;
    logic [3:0]    v4_in_b;
    logic          v4_in_cin;
    logic          v4_out_valid;
    logic          v4_out_ready;
    logic [3:0]    v4_out_sum;
    logic          v4_out_cout;
    logic          v4_out_ovf;
    logic          v4_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    serial_wide_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef WADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    serial_wide_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4_in_valid),
        .in_ready  (v4_in_ready),
        .in_a      (v4_in_a),
        .in_b      (v4_in_b),
        .in_cin    (v4_in_cin),
`ifdef WADD_SUB_EN
        .op_sub    (v4_op_sub),
`endif
        .out_valid (v4_out_valid),
        .out_ready (v4_out_ready),
        .out_sum   (v4_out_sum),
        .out_cout  (v4_out_cout),
        .out_ovf   (v4_out_ovf),
        .busy      (v4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: one outstanding operation, result = A + Beff + c,
    // visible NIB cycles after the accepting edge, held until out_ready.
    bit           m_pending = 1'b0;
    int           m_acc     = 0;
    logic [W-1:0] m_sum     = '0;
    logic         m_cout    = 1'b0;
    logic         m_ovf     = 1'b0;

    always @(negedge clk) begin
        logic         exp_valid;
        logic [W:0]   full;
        logic [W-1:0] beff;
        logic         c;
        if (!rst_n) begin
            m_pending = 1'b0;
            check("rst out_valid", out_valid, 0);
            check("rst in_ready",  in_ready, 1);
            check("rst busy",      busy, 0);
            check("rst out_sum",   out_sum, 0);
            check("rst out_cout",  out_cout, 0);
            check("rst out_ovf",   out_ovf, 0);
        end else begin
            exp_valid = m_pending && (cyc >= m_acc + NIB);
            check("out_valid", out_valid, exp_valid);
            check("in_ready",  in_ready, !m_pending);
            check("busy",      busy, m_pending);
            if (exp_valid) begin
                check("out_sum",  out_sum, m_sum);
                check("out_cout", out_cout, m_cout);
                check("out_ovf",  out_ovf, m_ovf);
            end
            if (exp_valid && out_ready) begin
                m_pending = 1'b0;
            end else if (!m_pending && in_valid) begin
                beff = in_b;
                c    = in_cin;
`ifdef WADD_SUB_EN
                if (op_sub) begin
                    beff = ~in_b;
                    c    = 1'b1;
                end
`endif
                full      = {1'b0, in_a} + {1'b0, beff} + (W + 1)'(c);
                m_sum     = full[W-1:0];
                m_cout    = full[W];
                m_ovf     = (in_a[W-1] == beff[W-1]) && (full[W-1] != in_a[W-1]);
                m_pending = 1'b1;
                m_acc     = cyc + 1;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic hold, input int bp,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int acc;
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
`ifdef WADD_SUB_EN
        op_sub = sub;
`else
        if (sub) $display("note: subtract vector skipped in add-only build");
`endif
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_cin = 1'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = cyc - acc;
                break;
            end
        end
        check("result seen", seen, 1);
        check("latency", lat, NIB);
        check("lit sum",  out_sum, es);
        check("lit cout", out_cout, ec);
        check("lit ovf",  out_ovf, eo);
        if (bp > 0) begin
            repeat (bp) @(negedge clk);
            check("bp in_ready", in_ready, 0);
            check("bp busy",     busy, 1);
            check("bp out_valid", out_valid, 1);
            check("bp sum held", out_sum, es);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post hs out_valid", out_valid, 0);
        check("post hs in_ready",  in_ready, 1);
    endtask

    initial begin
        int acc4;
        int lat4;
        bit seen4;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        v4_in_valid = 1'b0; v4_in_a = '0; v4_in_b = '0; v4_in_cin = 1'b0; v4_out_ready = 1'b1;
`ifdef WADD_SUB_EN
        op_sub = 1'b0;
        v4_op_sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0);
        // backpressure with in_valid held through RUN
        run_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b1, 5, 16'hB4B5, 1'b0, 1'b0);

        // reset in the middle of RUN
        @(posedge clk); #1;
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy",      busy, 0);
        check("abort in_ready",  in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0);

`ifdef WADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
        op_sub = 1'b0;
`endif

        // 4-bit instance: single nibble, one-cycle latency
        seen4 = 1'b0;
        lat4  = 0;
        @(posedge clk); #1;
        v4_in_a = 4'hF; v4_in_b = 4'h1; v4_in_cin = 1'b1; v4_in_valid = 1'b1;
        @(posedge clk); #1;
        acc4 = cyc;
        v4_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (v4_out_valid) begin
                seen4 = 1'b1;
                lat4  = cyc - acc4;
                break;
            end
        end
        check("w4 seen",    seen4, 1);
        check("w4 latency", lat4, 1);
        check("w4 sum",     v4_out_sum, 4'h1);
        check("w4 cout",    v4_out_cout, 1);
        check("w4 ovf",     v4_out_ovf, 0);
        @(negedge clk);
        check("w4 idle", v4_in_ready, 1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
